pc_sequencer: RTL and testbench

Registered program-counter unit for the single-cycle LEGv8 datapath, superseding the purely combinational next-PC logic. Holds the PC, computes the next PC from sequential, conditional (CBZ/CBNZ), unconditional, register-indirect (BR) and return flows, and keeps a small return-address stack (RAS) for BL/RET. Sits between instruction fetch and the control/ALU outputs; PC feeds instruction memory directly.

---
 rtl/pc_sequencer.sv | 108 ++++++++++
 tb/tb_pc_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Registered LEGv8 program counter with next-PC selection and a circular return-address stack.
// NextPC and LinkAddr are combinational; PC, RAS pointer and count only change on clock edges.
module pc_sequencer #(
    parameter int unsigned      WIDTH     = 64,
    parameter logic [WIDTH-1:0] RESET_PC  = '0,
    parameter int unsigned      IMM_SHIFT = 0,
    parameter int unsigned      RAS_DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             stall_i,
    input  logic [WIDTH-1:0] sign_ext_imm_i,
    input  logic [WIDTH-1:0] reg_target_i,
    input  logic             branch_i,
    input  logic             branch_nz_i,
    input  logic             alu_zero_i,
    input  logic             uncond_branch_i,
    input  logic             link_i,
    input  logic             branch_reg_i,
    input  logic             return_i,
    output logic [WIDTH-1:0] pc_o,
    output logic [WIDTH-1:0] next_pc_o,
    output logic [WIDTH-1:0] link_addr_o,
    output logic             ras_empty_o,
    output logic             ras_full_o
);
    localparam int unsigned      PTR_W    = $clog2(RAS_DEPTH);
    localparam int unsigned      CNT_W    = $clog2(RAS_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [PTR_W-1:0] top_q, top_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] ras_q [RAS_DEPTH];

    logic [WIDTH-1:0] seq_pc;
    logic [WIDTH-1:0] tgt_pc;
    logic [WIDTH-1:0] next_pc;
    logic             cond_taken;
    logic             push;
    logic             pop;
    logic             ras_empty;
    logic             ras_full;

    assign seq_pc     = pc_q + WIDTH'(4);
    assign tgt_pc     = pc_q + (sign_ext_imm_i << IMM_SHIFT);
    assign cond_taken = branch_i & (alu_zero_i ^ branch_nz_i);
    assign ras_empty  = (cnt_q == '0);
    assign ras_full   = (cnt_q == CNT_FULL);
    // Return beats a simultaneous BL, so that BL never pushes.
    assign push       = uncond_branch_i & link_i & ~return_i;
    assign pop        = return_i & ~ras_empty;

    always_comb begin
        next_pc = seq_pc;
        if (return_i) begin
            next_pc = ras_empty ? reg_target_i : ras_q[top_q];
        end else if (branch_reg_i) begin
            next_pc = reg_target_i;
        end else if (uncond_branch_i || cond_taken) begin
            next_pc = tgt_pc;
        end
    end

    always_comb begin
        pc_d  = pc_q;
        top_d = top_q;
        cnt_d = cnt_q;
        if (!stall_i) begin
            pc_d = next_pc;
            if (push) begin
                // A push into a full stack overwrites the oldest entry.
                top_d = top_q + PTR_W'(1);
                if (!ras_full) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else if (pop) begin
                top_d = top_q - PTR_W'(1);
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pc_q  <= RESET_PC;
            top_q <= '0;
            cnt_q <= '0;
        end else begin
            pc_q  <= pc_d;
            top_q <= top_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry storage is not reset; the count alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (!reset_i && !stall_i && push) begin
            ras_q[top_d] <= seq_pc;
        end
    end

    assign pc_o        = pc_q;
    assign next_pc_o   = next_pc;
    assign link_addr_o = seq_pc;
    assign ras_empty_o = ras_empty;
    assign ras_full_o  = ras_full;
endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: stimulus queues expected state per cycle, a monitor checks after each edge.
// Unit A uses byte offsets and RESET_PC=0x100; unit B shares the inputs and uses word offsets.
module tb_pc_sequencer;
    localparam int W = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, stall, branch, bnz, alu_zero, uncond, link, breg, ret;
    logic [W-1:0] imm, regt;
    logic [W-1:0] pc_a, np_a, la_a, pc_b, np_b, la_b;
    logic         e_a, f_a, e_b, f_b;

    pc_sequencer #(.WIDTH(W), .RESET_PC(64'h100), .IMM_SHIFT(0), .RAS_DEPTH(4)) dut_a (
        .clk_i(clk), .reset_i(reset), .stall_i(stall), .sign_ext_imm_i(imm),
        .reg_target_i(regt), .branch_i(branch), .branch_nz_i(bnz), .alu_zero_i(alu_zero),
        .uncond_branch_i(uncond), .link_i(link), .branch_reg_i(breg), .return_i(ret),
        .pc_o(pc_a), .next_pc_o(np_a), .link_addr_o(la_a), .ras_empty_o(e_a), .ras_full_o(f_a));

    pc_sequencer #(.WIDTH(W), .RESET_PC(64'h0), .IMM_SHIFT(2), .RAS_DEPTH(4)) dut_b (
        .clk_i(clk), .reset_i(reset), .stall_i(stall), .sign_ext_imm_i(imm),
        .reg_target_i(regt), .branch_i(branch), .branch_nz_i(bnz), .alu_zero_i(alu_zero),
        .uncond_branch_i(uncond), .link_i(link), .branch_reg_i(breg), .return_i(ret),
        .pc_o(pc_b), .next_pc_o(np_b), .link_addr_o(la_b), .ras_empty_o(e_b), .ras_full_o(f_b));

    // kind: 0 = unit A state, 1 = unit B PC, 2 = unit A NextPC/LinkAddr
    typedef struct {
        int           cyc;
        string        name;
        int           kind;
        logic [W-1:0] v0;
        logic [W-1:0] v1;
        bit           empty;
        bit           full;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;

    task automatic check(input exp_t e);
        tests++;
        case (e.kind)
            0: if (pc_a !== e.v0 || e_a !== e.empty || f_a !== e.full) begin
                fails++;
                $display("FAIL %s: pc=%h empty=%b full=%b, expected pc=%h empty=%b full=%b",
                         e.name, pc_a, e_a, f_a, e.v0, e.empty, e.full);
            end
            1: if (pc_b !== e.v0) begin
                fails++;
                $display("FAIL %s: pc_b=%h, expected %h", e.name, pc_b, e.v0);
            end
            default: if (np_a !== e.v0 || la_a !== e.v1) begin
                fails++;
                $display("FAIL %s: next_pc=%h link_addr=%h, expected next_pc=%h link_addr=%h",
                         e.name, np_a, la_a, e.v0, e.v1);
            end
        endcase
    endtask

    always begin
        @(posedge clk);
        #1;
        cyc++;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            check(e);
        end
    end

    task automatic clr_inputs();
        reset = 1'b0; stall = 1'b0; branch = 1'b0; bnz = 1'b0; alu_zero = 1'b0;
        uncond = 1'b0; link = 1'b0; breg = 1'b0; ret = 1'b0; imm = '0; regt = '0;
    endtask

    // Start a cycle: inputs applied now take effect on the next rising edge.
    task automatic begin_cycle();
        @(negedge clk);
        clr_inputs();
    endtask

    task automatic exp_a(input string name, input logic [W-1:0] pc, input bit e, input bit f);
        exp_t x;
        x.cyc = cyc + 1; x.name = name; x.kind = 0; x.v0 = pc; x.v1 = '0; x.empty = e; x.full = f;
        sb.push_back(x);
    endtask

    task automatic exp_b(input string name, input logic [W-1:0] pc);
        exp_t x;
        x.cyc = cyc + 1; x.name = name; x.kind = 1; x.v0 = pc; x.v1 = '0; x.empty = 1'b0; x.full = 1'b0;
        sb.push_back(x);
    endtask

    task automatic exp_np(input string name, input logic [W-1:0] np, input logic [W-1:0] la);
        exp_t x;
        x.cyc = cyc + 1; x.name = name; x.kind = 2; x.v0 = np; x.v1 = la; x.empty = 1'b0; x.full = 1'b0;
        sb.push_back(x);
    endtask

    task automatic do_idle(input string name, input logic [W-1:0] pc, input bit e, input bit f);
        begin_cycle();
        exp_a(name, pc, e, f);
    endtask

    task automatic do_br(input string name, input logic [W-1:0] t, input bit e, input bit f);
        begin_cycle();
        breg = 1'b1; regt = t;
        exp_a(name, t, e, f);
    endtask

    task automatic do_bl(input string name, input logic [W-1:0] im, input logic [W-1:0] pc,
                         input bit e, input bit f);
        begin_cycle();
        uncond = 1'b1; link = 1'b1; imm = im;
        exp_a(name, pc, e, f);
    endtask

    task automatic do_ret(input string name, input logic [W-1:0] rt, input logic [W-1:0] pc,
                          input bit e, input bit f);
        begin_cycle();
        ret = 1'b1; regt = rt;
        exp_a(name, pc, e, f);
    endtask

    task automatic do_cond(input string name, input bit az, input bit nz, input logic [W-1:0] im,
                           input logic [W-1:0] pc);
        begin_cycle();
        branch = 1'b1; alu_zero = az; bnz = nz; imm = im;
        exp_a(name, pc, 1'b1, 1'b0);
    endtask

    initial begin
        clr_inputs();
        reset = 1'b1;
        @(posedge clk);
        begin_cycle();
        reset = 1'b1;
        exp_a("reset", 64'h100, 1'b1, 1'b0);
        exp_b("reset_b", 64'h0);
        do_idle("idle1", 64'h104, 1'b1, 1'b0);
        do_idle("idle2", 64'h108, 1'b1, 1'b0);
        do_idle("idle3", 64'h10C, 1'b1, 1'b0);

        do_br  ("br_to_4a", 64'h4, 1'b1, 1'b0);
        do_cond("cbz_taken", 1'b1, 1'b0, 64'h32, 64'h36);
        do_br  ("br_to_4b", 64'h4, 1'b1, 1'b0);
        do_cond("cbz_not_taken", 1'b0, 1'b0, 64'h32, 64'h8);
        do_br  ("br_to_4c", 64'h4, 1'b1, 1'b0);
        do_cond("cbnz_taken", 1'b0, 1'b1, 64'h32, 64'h36);
        do_br  ("br_to_4d", 64'h4, 1'b1, 1'b0);
        do_cond("cbz_small", 1'b1, 1'b0, 64'h4, 64'h8);
        exp_b("imm_shift2", 64'h14);

        do_br  ("br_to_0a", 64'h0, 1'b1, 1'b0);
        do_bl  ("bl_outer", 64'h40, 64'h40, 1'b0, 1'b0);
        do_bl  ("bl_inner", 64'h40, 64'h80, 1'b0, 1'b0);
        exp_np ("bl_inner_np", 64'hC0, 64'h84);
        do_idle("nest_idle", 64'h84, 1'b0, 1'b0);
        do_ret ("ret_inner", 64'h999, 64'h44, 1'b0, 1'b0);
        do_ret ("ret_outer", 64'h999, 64'h4, 1'b1, 1'b0);
        do_ret ("ret_empty", 64'h200, 64'h200, 1'b1, 1'b0);

        do_br  ("br_to_0b", 64'h0, 1'b1, 1'b0);
        do_bl  ("ovf_bl1", 64'h10, 64'h10, 1'b0, 1'b0);
        do_bl  ("ovf_bl2", 64'h10, 64'h20, 1'b0, 1'b0);
        do_bl  ("ovf_bl3", 64'h10, 64'h30, 1'b0, 1'b0);
        do_bl  ("ovf_bl4", 64'h10, 64'h40, 1'b0, 1'b1);
        do_bl  ("ovf_bl5", 64'h10, 64'h50, 1'b0, 1'b1);
        do_ret ("ovf_ret1", 64'h999, 64'h44, 1'b0, 1'b0);
        do_ret ("ovf_ret2", 64'h999, 64'h34, 1'b0, 1'b0);
        do_ret ("ovf_ret3", 64'h999, 64'h24, 1'b0, 1'b0);
        do_ret ("ovf_ret4", 64'h999, 64'h14, 1'b1, 1'b0);

        do_br  ("br_to_0c", 64'h0, 1'b1, 1'b0);
        do_bl  ("stall_pre_bl", 64'h40, 64'h40, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            begin_cycle();
            stall = 1'b1; uncond = 1'b1; link = 1'b1; imm = 64'h20;
            exp_a ("stall_hold", 64'h40, 1'b0, 1'b0);
            exp_np("stall_np", 64'h60, 64'h44);
        end
        do_bl  ("stall_release", 64'h20, 64'h60, 1'b0, 1'b0);
        do_ret ("stall_ret1", 64'h999, 64'h44, 1'b0, 1'b0);
        do_ret ("stall_ret2", 64'h999, 64'h4, 1'b1, 1'b0);

        do_br  ("br_to_top", 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b0);
        do_idle("pc_wrap", 64'h0, 1'b1, 1'b0);
        do_bl  ("prio_bl1", 64'h40, 64'h40, 1'b0, 1'b0);
        do_bl  ("prio_bl2", 64'h40, 64'h80, 1'b0, 1'b0);
        begin_cycle();
        ret = 1'b1; breg = 1'b1; uncond = 1'b1; link = 1'b1; imm = 64'h10; regt = 64'h300;
        exp_a  ("prio_all", 64'h44, 1'b0, 1'b0);
        do_ret ("prio_no_push", 64'h999, 64'h4, 1'b1, 1'b0);

        do_bl  ("pre_reset_bl", 64'h40, 64'h44, 1'b0, 1'b0);
        begin_cycle();
        reset = 1'b1; stall = 1'b1;
        exp_a  ("reset_over_stall", 64'h100, 1'b1, 1'b0);
        do_ret ("ret_after_reset", 64'h250, 64'h250, 1'b1, 1'b0);

        begin_cycle();
        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time exceeded, expected completion");
        $fatal(1, "timeout");
    end
endmodule
